// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared CPU types and constants for the fetch stage
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_hold_buf.sv
// fetch_hold_buf: parks one fetched word and its pc while decode is stalled
module fetch_hold_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] d_word,
    input  logic [31:0] d_pc,
    output logic [31:0] word,
    output logic [31:0] pc,
    output logic        valid
);

    // clear wins over load so a redirect always empties the buffer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            word  <= 32'd0;
            pc    <= 32'd0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            word  <= d_word;
            pc    <= d_pc;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding-request fetch stage feeding the IF/ID register
import instr_fetch_pkg::*;

module instr_fetch #(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        noop_o
);

    fetch_state_t state, state_nx;
    logic [31:0]  pc, pc_nx, drop_addr;
    logic [31:0]  instr_nx, pc_o_nx;
    logic         noop_nx;
    logic         hb_load, hb_clear, hb_valid;
    logic [31:0]  hb_word, hb_pc;

    fetch_hold_buf u_hold (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .load   (hb_load),
        .clear  (hb_clear),
        .d_word (imem_rdata_i),
        .d_pc   (pc),
        .word   (hb_word),
        .pc     (hb_pc),
        .valid  (hb_valid)
    );

    // state register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= FETCH;
        else          state <= state_nx;
    end

    // next state: redirect only changes state when it must orphan an outstanding request
    always_comb begin
        state_nx = state;
        case (state)
            FETCH:   state_nx = redirect_i ? (imem_rvalid_i ? FETCH : DROP)
                              : (imem_rvalid_i && stall_i) ? HOLD : FETCH;
            HOLD:    state_nx = (redirect_i || !stall_i) ? FETCH : HOLD;
            DROP:    state_nx = imem_rvalid_i ? FETCH : DROP;
            default: state_nx = FETCH;
        endcase
    end

    // outputs: memory request side plus next values of pc and the IF/ID register
    always_comb begin
        imem_req_o  = rst_n_i && (state != HOLD);
        imem_addr_o = (state == DROP) ? drop_addr : pc;
        hb_load     = (state == FETCH) && imem_rvalid_i && stall_i && !redirect_i;
        hb_clear    = redirect_i || ((state == HOLD) && !stall_i);
        pc_nx       = redirect_i ? align_word(redirect_pc_i)
                    : (!stall_i && ((state == HOLD) || ((state == FETCH) && imem_rvalid_i))) ? pc + 32'd4
                    : pc;
        instr_nx    = NOP_INSTR;
        pc_o_nx     = pc_o;
        noop_nx     = 1'b1;
        if (!redirect_i && stall_i) begin
            instr_nx = instr_o;
            noop_nx  = noop_o;
        end else if (!redirect_i && (state == FETCH) && imem_rvalid_i) begin
            instr_nx = imem_rdata_i;
            pc_o_nx  = pc;
            noop_nx  = 1'b0;
        end else if (!redirect_i && (state == HOLD) && hb_valid) begin
            instr_nx = hb_word;
            pc_o_nx  = hb_pc;
            noop_nx  = 1'b0;
        end
    end

    // pc, orphaned-request address and IF/ID register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc        <= PC_RESET;
            drop_addr <= PC_RESET;
            instr_o   <= NOP_INSTR;
            pc_o      <= 32'd0;
            noop_o    <= 1'b1;
        end else begin
            pc      <= pc_nx;
            instr_o <= instr_nx;
            pc_o    <= pc_o_nx;
            noop_o  <= noop_nx;
            if ((state == FETCH) && redirect_i && !imem_rvalid_i) drop_addr <= pc;
        end
    end

endmodule
